// File: rtl/trs_bus_pkg.sv
// rtl/trs_bus_pkg.sv - shared types and constants for the TRS-80 bus capture front end
package trs_bus_pkg;

    typedef enum logic [1:0] {
        ARMED,
        FALL,
        LOW,
        RISE
    } filt_state_t;

    localparam logic [15:0] DSP_BASE_DEF   = 16'h3C00;
    localparam logic [7:0]  PORT_MOD_DEF   = 8'hEC;
    localparam logic [7:0]  PORT_OPREG_DEF = 8'h84;
    localparam logic [15:0] DSP_SIZE       = 16'd1024;

    localparam int MOD_MODSEL_BIT    = 2;
    localparam int MOD_ENALTSET_BIT  = 3;
    localparam int OPREG_INVVIDE_BIT = 5;
    localparam int OPREG_PAGE_BIT    = 7;

    // Wrapping subtraction so addresses below the base fall outside the window.
    function automatic logic in_dsp_window(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] offset;
        offset = addr - base;
        return offset < DSP_SIZE;
    endfunction

endpackage

// File: rtl/strobe_filter.sv
// rtl/strobe_filter.sv - synchronizer plus debounce FSM producing a one-cycle accept on a qualified low strobe
module strobe_filter
    import trs_bus_pkg::*;
#(
    parameter int FILTER = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic accept
);

    localparam logic [3:0] FILT = 4'(FILTER);

    logic [1:0]  sync;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        level;
    filt_state_t state;

    assign level   = sync[1];
    assign cnt_nxt = cnt + 4'd1;

    // Starts in LOW so a strobe already asserted at reset release never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= 2'b00;
            cnt    <= 4'd0;
            state  <= LOW;
            accept <= 1'b0;
        end else begin
            sync   <= {sync[0], strobe_n};
            accept <= 1'b0;
            case (state)
                ARMED: begin
                    if (!level) begin
                        cnt <= 4'd1;
                        if (FILT == 4'd1) begin
                            accept <= 1'b1;
                            state  <= LOW;
                        end else begin
                            state <= FALL;
                        end
                    end
                end
                FALL: begin
                    if (level) begin
                        state <= ARMED;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == FILT) begin
                            accept <= 1'b1;
                            state  <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (level) begin
                        cnt   <= 4'd1;
                        state <= (FILT == 4'd1) ? ARMED : RISE;
                    end
                end
                RISE: begin
                    if (!level) begin
                        state <= LOW;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == FILT) begin
                            state <= ARMED;
                        end
                    end
                end
                default: state <= LOW;
            endcase
        end
    end

endmodule

// File: rtl/trs_bus_capture.sv
// rtl/trs_bus_capture.sv - samples the Z80 bus, latches display writes and decodes video mode ports
module trs_bus_capture
    import trs_bus_pkg::*;
#(
    parameter int          FILTER     = 3,
    parameter logic [15:0] DSP_BASE   = DSP_BASE_DEF,
    parameter logic [7:0]  PORT_MOD   = PORT_MOD_DEF,
    parameter logic [7:0]  PORT_OPREG = PORT_OPREG_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_a,
    input  logic [7:0]  bus_d,
    input  logic        bus_wr_n,
    input  logic        bus_out_n,
    output logic [15:0] trs_a,
    output logic [7:0]  TRS_D,
    output logic        WR_falling_edge,
    output logic        z80_dsp_sel,
    output logic        mod_modsel,
    output logic        mod_enaltset,
    output logic        opreg_invvide,
    output logic        opreg_page
);

    logic [15:0] a_s1, a_s2;
    logic [7:0]  d_s1, d_s2;
    logic        wr_accept;
    logic        io_accept;

    strobe_filter #(.FILTER(FILTER)) u_wr_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (bus_wr_n),
        .accept   (wr_accept)
    );

    strobe_filter #(.FILTER(FILTER)) u_out_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (bus_out_n),
        .accept   (io_accept)
    );

    // Same two-flop depth as the strobes; values are long settled by accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1 <= 16'd0;
            a_s2 <= 16'd0;
            d_s1 <= 8'd0;
            d_s2 <= 8'd0;
        end else begin
            a_s1 <= bus_a;
            a_s2 <= a_s1;
            d_s1 <= bus_d;
            d_s2 <= d_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trs_a           <= 16'd0;
            TRS_D           <= 8'd0;
            WR_falling_edge <= 1'b0;
            z80_dsp_sel     <= 1'b0;
            mod_modsel      <= 1'b0;
            mod_enaltset    <= 1'b0;
            opreg_invvide   <= 1'b0;
            opreg_page      <= 1'b0;
        end else begin
            WR_falling_edge <= wr_accept;
            if (wr_accept) begin
                trs_a       <= a_s2;
                TRS_D       <= d_s2;
                z80_dsp_sel <= in_dsp_window(a_s2, DSP_BASE);
            end
            if (io_accept && a_s2[7:0] == PORT_MOD) begin
                mod_modsel   <= d_s2[MOD_MODSEL_BIT];
                mod_enaltset <= d_s2[MOD_ENALTSET_BIT];
            end
            if (io_accept && a_s2[7:0] == PORT_OPREG) begin
                opreg_invvide <= d_s2[OPREG_INVVIDE_BIT];
                opreg_page    <= d_s2[OPREG_PAGE_BIT];
            end
        end
    end

endmodule

// File: tb/tb_trs_bus_capture.sv
// tb/tb_trs_bus_capture.sv - scoreboard bench for trs_bus_capture
module tb_trs_bus_capture;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_wr_n;
    logic        bus_out_n;
    logic [15:0] trs_a;
    logic [7:0]  TRS_D;
    logic        WR_falling_edge;
    logic        z80_dsp_sel;
    logic        mod_modsel;
    logic        mod_enaltset;
    logic        opreg_invvide;
    logic        opreg_page;

    trs_bus_capture dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_a           (bus_a),
        .bus_d           (bus_d),
        .bus_wr_n        (bus_wr_n),
        .bus_out_n       (bus_out_n),
        .trs_a           (trs_a),
        .TRS_D           (TRS_D),
        .WR_falling_edge (WR_falling_edge),
        .z80_dsp_sel     (z80_dsp_sel),
        .mod_modsel      (mod_modsel),
        .mod_enaltset    (mod_enaltset),
        .opreg_invvide   (opreg_invvide),
        .opreg_page      (opreg_page)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        sel;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          n_exp = 0;
    logic [15:0] last_a = 16'd0;
    logic        m_modsel = 0, m_altset = 0, m_invvide = 0, m_page = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_sel(input logic [15:0] a);
        return (a >= 16'h3C00) && (a <= 16'h3FFF);
    endfunction

    always @(negedge clk) begin
        if (rst_n && WR_falling_edge) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("pulse_cycle", e.cyc, cyc);
                check_eq("trs_a", trs_a, e.a);
                check_eq("trs_d", TRS_D, e.d);
                check_eq("dsp_sel", z80_dsp_sel, e.sel);
            end
        end
    end

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.a = a; e.d = d; e.sel = exp_sel(a); e.cyc = cyc + 6;
        sb.push_back(e);
        n_exp++;
        last_a = a;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d, input int low);
        @(negedge clk);
        bus_a = a; bus_d = d; bus_wr_n = 0;
        if (low >= 3) push_exp(a, d);
        repeat (low) @(negedge clk);
        bus_wr_n = 1;
        repeat (10) @(negedge clk);
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] d);
        @(negedge clk);
        bus_a = {8'h5A, port}; bus_d = d; bus_out_n = 0;
        repeat (10) @(negedge clk);
        bus_out_n = 1;
        repeat (10) @(negedge clk);
        if (port == 8'hEC) begin m_modsel = d[2]; m_altset = d[3]; end
        if (port == 8'h84) begin m_invvide = d[5]; m_page = d[7]; end
        check_eq("mod_modsel", mod_modsel, m_modsel);
        check_eq("mod_enaltset", mod_enaltset, m_altset);
        check_eq("opreg_invvide", opreg_invvide, m_invvide);
        check_eq("opreg_page", opreg_page, m_page);
        check_eq("io_keeps_trs_a", trs_a, last_a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n = 0; bus_a = 0; bus_d = 0; bus_wr_n = 0; bus_out_n = 1;
        repeat (3) @(negedge clk);
        check_eq("rst_trs_a", trs_a, 0);
        check_eq("rst_trs_d", TRS_D, 0);
        check_eq("rst_wr", WR_falling_edge, 0);
        check_eq("rst_sel", z80_dsp_sel, 0);
        check_eq("rst_modes", {mod_modsel, mod_enaltset, opreg_invvide, opreg_page}, 0);
        rst_n = 1;
        repeat (20) @(negedge clk);
        bus_wr_n = 1;
        repeat (10) @(negedge clk);
        check_eq("no_pulse_after_reset", pulses, 0);

        mem_write(16'h3C05, 8'h41, 10);
        mem_write(16'h3BFF, 8'h12, 5);
        mem_write(16'h4000, 8'h34, 5);
        mem_write(16'h3FFF, 8'h56, 5);

        mem_write(16'h3C10, 8'hAA, 1);
        mem_write(16'h3C11, 8'hBB, 2);
        mem_write(16'h3C12, 8'hCC, 3);

        @(negedge clk);
        bus_a = 16'h3D00; bus_d = 8'h77; bus_wr_n = 0;
        push_exp(16'h3D00, 8'h77);
        repeat (10) @(negedge clk);
        bus_wr_n = 1;
        repeat (2) @(negedge clk);
        bus_wr_n = 0;
        repeat (8) @(negedge clk);
        bus_wr_n = 1;
        repeat (10) @(negedge clk);
        check_eq("glitch_queue_empty", sb.size(), 0);

        io_write(8'hEC, 8'h0C);
        io_write(8'h84, 8'hA0);
        io_write(8'h85, 8'hFF);
        io_write(8'hEC, 8'h00);

        @(negedge clk);
        bus_a = 16'h00EC; bus_d = 8'h04; bus_wr_n = 0; bus_out_n = 0;
        t = cyc + 6;
        push_exp(16'h00EC, 8'h04);
        while (cyc < t - 1) @(negedge clk);
        check_eq("both_pre_wr", WR_falling_edge, 0);
        check_eq("both_pre_modsel", mod_modsel, 0);
        @(negedge clk);
        check_eq("both_wr", WR_falling_edge, 1);
        check_eq("both_modsel", mod_modsel, 1);
        #2 rst_n = 0;
        #1;
        check_eq("rst_mid_wr", WR_falling_edge, 0);
        check_eq("rst_mid_modsel", mod_modsel, 0);
        check_eq("rst_mid_invvide", opreg_invvide, 0);
        check_eq("rst_mid_trs_a", trs_a, 0);
        repeat (5) @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        bus_wr_n = 1; bus_out_n = 1;
        repeat (15) @(negedge clk);
        check_eq("no_replay_modsel", mod_modsel, 0);
        check_eq("final_queue_empty", sb.size(), 0);
        check_eq("pulse_count", pulses, n_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
